// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, reset constants and types for the fetch stage
package fetch_unit_pkg;
  localparam int ADDR = 8;
  localparam int WORD = 32;
  localparam logic [ADDR-1:0] RESET_PC_DEFAULT = '0;
  localparam int FQ_DEPTH = 2;
  typedef enum logic {RUN, HALTED} fetch_state_t;
  typedef struct packed {
    logic [ADDR-1:0] pc;
    logic [WORD-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry skid buffer holding {pc, inst}; flush beats push, push accepted alongside pop
module fetch_skid_fifo
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   occ,
  output fetch_entry_t head
);
  fetch_entry_t tail;
  logic pop_ok, push_ok;
  // head is entry 0 and drives the outputs directly; tail is the overflow slot
  always_comb begin
    pop_ok = pop && occ != 2'd0;
    push_ok = push && (occ != 2'd2 || pop_ok);
  end
  // shift-style storage: a pop moves tail into head, a push fills the first free slot
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      occ <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      if (push_ok && (occ == 2'd0 || (occ == 2'd1 && pop_ok))) head <= din;
      else if (pop_ok && occ == 2'd2) head <= tail;
      if (push_ok && ((occ == 2'd1 && !pop_ok) || (occ == 2'd2 && pop_ok))) tail <= din;
      occ <= occ + {1'b0, push_ok} - {1'b0, pop_ok};
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and fetch stage with skid buffer; FETCH_STATS_EN adds handshake/stall counters
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic [ADDR-1:0] imem_a,
  output logic            imem_w,
  input  logic [WORD-1:0] imem_q,
  input  logic            redirect_valid,
  input  logic [ADDR-1:0] redirect_pc,
  input  logic            halt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_inst,
  output logic [ADDR-1:0] out_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_stall
`endif
);
  fetch_state_t state, state_nx;
  logic [ADDR-1:0] pc, req_pc;
  logic req_q, pop, issue;
  logic [1:0] occ;
  logic [2:0] load;
  fetch_entry_t head;

  assign imem_w = 1'b0;
  assign imem_a = rst ? RESET_PC : redirect_valid ? redirect_pc : pc;
  assign out_valid = occ != 2'd0;
  assign out_pc = head.pc;
  assign out_inst = head.inst;
  assign pop = out_valid & out_ready;

  // issue only if the buffer can still absorb the read; a redirect always issues, even while halted
  always_comb begin
    load = {1'b0, occ} + {2'b0, req_q} - {2'b0, pop};
    issue = redirect_valid || (state == RUN && load <= 3'd1);
    state_nx = halt ? HALTED : RUN;
  end

  // pc, in-flight request tracking and run/halt state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
      req_q <= 1'b0;
      req_pc <= '0;
    end else begin
      state <= state_nx;
      req_q <= issue;
      if (issue) begin
        req_pc <= imem_a;
        pc <= imem_a + 1'b1;
      end
    end

  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_q),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ('{pc: req_pc, inst: imem_q}),
    .occ   (occ),
    .head  (head)
  );

`ifdef FETCH_STATS_EN
  // saturating counters of delivered instructions and back-pressured cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_fetched <= '0;
      stat_stall <= '0;
    end else begin
      if (pop && !(&stat_fetched)) stat_fetched <= stat_fetched + 32'd1;
      if (out_valid && !out_ready && !(&stat_stall)) stat_stall <= stat_stall + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven check of fetch_unit against hand-computed outputs
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    logic            rdy;
    logic            rv;
    logic [ADDR-1:0] rpc;
    logic            hlt;
    logic            ev;
    logic [ADDR-1:0] epc;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [ADDR-1:0] imem_a, redirect_pc = '0, out_pc;
  logic [WORD-1:0] imem_q = '0, out_inst;
  logic imem_w, redirect_valid = 1'b0, halt = 1'b0, out_valid, out_ready = 1'b0;
  logic [WORD-1:0] mem [2**ADDR];
  int n_chk = 0, n_fail = 0;
  vec_t v[34];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_a         (imem_a),
    .imem_w         (imem_w),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_q <= mem[imem_a];

  function automatic logic [WORD-1:0] memval(input logic [ADDR-1:0] a);
    return 32'hA000_0000 + 32'(a) * 32'h0001_0003;
  endfunction

  function automatic vec_t mk(input logic rdy, rv, input logic [ADDR-1:0] rpc,
                              input logic hlt, ev, input logic [ADDR-1:0] epc);
    return '{rdy: rdy, rv: rv, rpc: rpc, hlt: hlt, ev: ev, epc: epc};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADDR-1:0] rst_pc [5];
    logic rst_v [5];
    for (int i = 0; i < 2**ADDR; i++) mem[i] = memval(ADDR'(i));
    v = '{
      mk(1,0,8'h00,0, 0,8'h00), mk(1,0,8'h00,0, 0,8'h00), mk(1,0,8'h00,0, 1,8'h00),
      mk(1,0,8'h00,0, 1,8'h01), mk(1,0,8'h00,0, 1,8'h02), mk(0,0,8'h00,0, 1,8'h03),
      mk(0,0,8'h00,0, 1,8'h03), mk(0,0,8'h00,0, 1,8'h03), mk(0,0,8'h00,0, 1,8'h03),
      mk(0,0,8'h00,0, 1,8'h03), mk(1,0,8'h00,0, 1,8'h03), mk(1,0,8'h00,0, 1,8'h04),
      mk(1,0,8'h00,0, 1,8'h05), mk(0,0,8'h00,0, 1,8'h06), mk(0,1,8'h20,0, 1,8'h06),
      mk(1,0,8'h00,0, 0,8'h00), mk(1,0,8'h00,0, 1,8'h20), mk(1,1,8'h40,0, 1,8'h21),
      mk(1,0,8'h00,0, 0,8'h00), mk(1,0,8'h00,0, 1,8'h40), mk(1,0,8'h00,0, 1,8'h41),
      mk(1,0,8'h00,1, 1,8'h42), mk(1,0,8'h00,1, 1,8'h43), mk(1,0,8'h00,1, 1,8'h44),
      mk(1,0,8'h00,1, 0,8'h00), mk(1,0,8'h00,0, 0,8'h00), mk(1,0,8'h00,0, 0,8'h00),
      mk(1,0,8'h00,0, 0,8'h00), mk(1,0,8'h00,0, 1,8'h45), mk(1,1,8'hFF,0, 1,8'h46),
      mk(1,0,8'h00,0, 0,8'h00), mk(1,0,8'h00,0, 1,8'hFF), mk(1,0,8'h00,0, 1,8'h00),
      mk(1,0,8'h00,0, 1,8'h01)
    };
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_pc", out_pc, 0);
    chk("reset out_inst", out_inst, 0);
    chk("reset imem_a", imem_a, 0);
    chk("reset imem_w", imem_w, 0);
    rst = 1'b0;
    for (int k = 0; k < 34; k++) begin
      chk($sformatf("row%0d out_valid", k), out_valid, v[k].ev);
      if (v[k].ev) begin
        chk($sformatf("row%0d out_pc", k), out_pc, v[k].epc);
        chk($sformatf("row%0d out_inst", k), out_inst, memval(v[k].epc));
      end
      chk($sformatf("row%0d imem_w", k), imem_w, 0);
      out_ready = v[k].rdy;
      redirect_valid = v[k].rv;
      redirect_pc = v[k].rpc;
      halt = v[k].hlt;
      @(negedge clk);
    end
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    halt = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_pc", out_pc, 0);
    chk("midrst out_inst", out_inst, 0);
    chk("midrst imem_a", imem_a, 0);
    @(negedge clk);
    rst = 1'b0;
    rst_v = '{0, 0, 1, 1, 1};
    rst_pc = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("restart%0d out_valid", k), out_valid, rst_v[k]);
      if (rst_v[k]) begin
        chk($sformatf("restart%0d out_pc", k), out_pc, rst_pc[k]);
        chk($sformatf("restart%0d out_inst", k), out_inst, memval(rst_pc[k]));
      end
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
